// File: rtl/replicated_fork_pkg.sv
// Shared definitions for the replicated fork: state encoding and width helpers.
package replicated_fork_pkg;

    // Broadcast controller states.
    typedef enum logic {
        IDLE  = 1'b0,
        BCAST = 1'b1
    } state_e;

    // 2**l, used to derive data width and way count from their log2 parameters.
    function automatic int unsigned pow2(input int unsigned l);
        return 32'd1 << l;
    endfunction

endpackage : replicated_fork_pkg

// File: rtl/replicated_fork_replicator.sv
// Combinational fan-out of one W-bit word onto N ways.
// Ports:
//   in_data  [W-1:0]   word to replicate
//   out_data [N*W-1:0] way i receives in_data at [i*W +: W]
module replicator
    import replicated_fork_pkg::*;
#(
    parameter int unsigned WIRE = 3,
    parameter int unsigned WAY  = 2
) (
    input  logic [pow2(WIRE)-1:0]            in_data,
    output logic [pow2(WAY)*pow2(WIRE)-1:0]  out_data
);

    localparam int unsigned W = pow2(WIRE);
    localparam int unsigned N = pow2(WAY);

    // One copy per way.
    for (genvar i = 0; i < N; i++) begin : g_way
        assign out_data[i*W +: W] = in_data;
    end

endmodule : replicator

// File: rtl/replicated_fork.sv
// Registered broadcast stage: holds one word and offers it to every way,
// retiring it only once all ways have accepted.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    producer handshake (in_ready is combinational)
//   in_data   [W-1:0]    producer word
//   out_valid [N-1:0]    per-way pending copy
//   out_ready [N-1:0]    per-way accept
//   out_data  [N*W-1:0]  replicated held word
//   busy                 a word is held
//   words_done [CNTW-1:0] count of fully retired words (wraps)
module replicated_fork
    import replicated_fork_pkg::*;
#(
    parameter int unsigned WIRE = 3,
    parameter int unsigned WAY  = 2,
    parameter int unsigned CNTW = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [pow2(WIRE)-1:0]           in_data,
    output logic [pow2(WAY)-1:0]            out_valid,
    input  logic [pow2(WAY)-1:0]            out_ready,
    output logic [pow2(WAY)*pow2(WIRE)-1:0] out_data,
    output logic                            busy,
    output logic [CNTW-1:0]                 words_done
);

    localparam int unsigned W = pow2(WIRE);
    localparam int unsigned N = pow2(WAY);

    // Way count must be 2..32.
    if (WAY < 1 || WAY > 5) begin : g_way_check
        $error("replicated_fork: WAY must be in 1..5");
    end

    state_e          state_q, state_d;
    logic [N-1:0]    pend_q, pend_d;
    logic [W-1:0]    data_q, data_d;
    logic [CNTW-1:0] cnt_d;
    logic            last;
    logic            load;

    // Every still-pending way accepts this cycle.
    assign last     = (state_q == BCAST) && ((pend_q & ~out_ready) == '0);
    assign in_ready = (state_q == IDLE) || last;
    assign load     = in_valid && in_ready;

    assign out_valid = pend_q;
    assign busy      = (state_q == BCAST);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            data_q     <= '0;
            words_done <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            data_q     <= data_d;
            words_done <= cnt_d;
        end
    end

    // Next-state, pending mask, held word and retire counter.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        data_d  = data_q;
        cnt_d   = words_done;
        case (state_q)
            IDLE: begin
                if (load) begin
                    data_d  = in_data;
                    pend_d  = '1;
                    state_d = BCAST;
                end
            end
            BCAST: begin
                if (!last) begin
                    pend_d = pend_q & ~out_ready;
                end else if (load) begin
                    // Final way retires and the next word loads in the same cycle.
                    data_d = in_data;
                    pend_d = '1;
                end else begin
                    pend_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = '0;
            end
        endcase
        if (last) begin
            cnt_d = words_done + CNTW'(1);
        end
    end

    replicator #(
        .WIRE(WIRE),
        .WAY (WAY)
    ) u_replicator (
        .in_data (data_q),
        .out_data(out_data)
    );

endmodule : replicated_fork

// File: tb/tb_replicated_fork.sv
// Directed bench for replicated_fork (W=8, N=4) plus a CNTW=4 instance for counter wrap.
module tb_replicated_fork;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic [15:0] words_done;

    logic        in_ready4;
    logic [3:0]  out_valid4;
    logic [31:0] out_data4;
    logic        busy4;
    logic [3:0]  words_done4;

    int checks = 0;
    int errors = 0;
    int exp_done = 0;

    replicated_fork #(.WIRE(3), .WAY(2), .CNTW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .words_done(words_done)
    );

    replicated_fork #(.WIRE(3), .WAY(2), .CNTW(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .in_data   (in_data),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_data  (out_data4),
        .busy      (busy4),
        .words_done(words_done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 4'h0;
        #3;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 4'h0 || busy !== 1'b0 || out_data !== 32'h0 || words_done !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%h busy=%b data=%h done=%h want all 0", out_valid, busy, out_data, words_done);
        end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 4'hF;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL single_idle_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_data !== 32'hA5A5A5A5 || out_valid !== 4'hF || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_bcast: data=%h valid=%h busy=%b want A5A5A5A5 F 1", out_data, out_valid, busy);
        end
        step();
        exp_done++;
        checks++;
        if (words_done !== 16'(exp_done) || busy !== 1'b0 || out_valid !== 4'h0) begin
            errors++;
            $display("FAIL single_retire: done=%0d busy=%b valid=%h want %0d 0 0", words_done, busy, out_valid, exp_done);
        end
    endtask

    task automatic test_staggered();
        logic [3:0] rdy [3];
        logic [3:0] exp_v [3];
        logic       exp_r [3];
        rdy[0] = 4'b0001; rdy[1] = 4'b0100; rdy[2] = 4'b1010;
        exp_v[0] = 4'b1111; exp_v[1] = 4'b1110; exp_v[2] = 4'b1010;
        exp_r[0] = 1'b0; exp_r[1] = 1'b0; exp_r[2] = 1'b1;
        in_valid = 1'b1; in_data = 8'h3C; out_ready = 4'h0;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            out_ready = rdy[k];
            #1;
            checks++;
            if (out_valid !== exp_v[k] || in_ready !== exp_r[k] || out_data !== 32'h3C3C3C3C) begin
                errors++;
                $display("FAIL stagger_step%0d: valid=%b ready=%b data=%h want %b %b 3C3C3C3C",
                         k, out_valid, in_ready, out_data, exp_v[k], exp_r[k]);
            end
            step();
        end
        out_ready = 4'h0;
        exp_done++;
        checks++;
        if (out_valid !== 4'h0 || busy !== 1'b0 || words_done !== 16'(exp_done)) begin
            errors++;
            $display("FAIL stagger_done: valid=%b busy=%b done=%0d want 0000 0 %0d", out_valid, busy, words_done, exp_done);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = exp_done;
        out_ready = 4'hF;
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = 8'(k);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", k, in_ready); end
            step();
            checks++;
            if (out_data !== {4{8'(k)}} || out_valid !== 4'hF || words_done !== 16'(base + k)) begin
                errors++;
                $display("FAIL b2b_word%0d: data=%h valid=%h done=%0d want %h F %0d",
                         k, out_data, out_valid, words_done, {4{8'(k)}}, base + k);
            end
        end
        in_valid = 1'b0;
        step();
        exp_done = base + 8;
        checks++;
        if (words_done !== 16'(exp_done) || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_total: done=%0d busy=%b want %0d 0", words_done, busy, exp_done);
        end
        out_ready = 4'h0;
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_data = 8'h5A; out_ready = 4'h0;
        step();
        in_data = 8'hFF; out_ready = 4'b0111;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_first_ready: got %b want 0", in_ready); end
        step();
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if (out_valid !== 4'b1000 || out_data !== 32'h5A5A5A5A || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d: valid=%b data=%h ready=%b want 1000 5A5A5A5A 0",
                         k, out_valid, out_data, in_ready);
            end
            step();
        end
        out_ready = 4'hF;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
        step();
        exp_done++;
        in_valid = 1'b0;
        checks++;
        if (out_data !== 32'hFFFFFFFF || out_valid !== 4'hF || words_done !== 16'(exp_done)) begin
            errors++;
            $display("FAIL stall_newword: data=%h valid=%h done=%0d want FFFFFFFF F %0d",
                     out_data, out_valid, words_done, exp_done);
        end
        step();
        exp_done++;
        out_ready = 4'h0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_data = 8'h11; out_ready = 4'h0;
        step();
        in_valid = 1'b0; out_ready = 4'b1010;
        step();
        out_ready = 4'h0;
        #1;
        checks++;
        if (out_valid !== 4'b0101 || busy !== 1'b1 || words_done !== 16'(exp_done)) begin
            errors++;
            $display("FAIL rstmid_pre: valid=%b busy=%b done=%0d want 0101 1 %0d", out_valid, busy, words_done, exp_done);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'h0 || busy !== 1'b0 || in_ready !== 1'b1 || words_done !== 16'h0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_async: valid=%b busy=%b ready=%b done=%0d data=%h want 0000 0 1 0 0",
                     out_valid, busy, in_ready, words_done, out_data);
        end
        exp_done = 0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_wrap();
        out_ready = 4'hF;
        in_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            in_data = 8'(k + 8'h40);
            step();
        end
        in_valid = 1'b0;
        step();
        exp_done += 17;
        checks++;
        if (words_done4 !== 4'h1) begin errors++; $display("FAIL wrap_cnt4: got %h want 1", words_done4); end
        checks++;
        if (words_done !== 16'(exp_done)) begin errors++; $display("FAIL wrap_cnt16: got %0d want %0d", words_done, exp_done); end
        out_ready = 4'h0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_staggered();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_replicated_fork
